// File: rtl/des_block_sequencer.sv
// des_block_sequencer
// Steps a round-serial DES core over a run of 64-bit blocks: each block is read
// as two 32-bit words from the input RAM, run through 16 rounds (plus an
// optional capture delay), and written as two words to the output RAM.
// Host side: start/abort are single-cycle pulses; busy covers the whole run;
// done pulses once on normal completion only.
// Optional feature macro: DES_CBC_EN adds CBC chaining through a 64-bit chain
// register loaded from iv at start. Without it the block is pure ECB.
module des_block_sequencer #(
    parameter int ADDR_W      = 9,
    parameter int CAPTURE_DLY = 0
) (
    input  logic              ti_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              decrypt,
    input  logic [ADDR_W-2:0] blk_count,
    input  logic [63:0]       iv,
    output logic [ADDR_W-1:0] ramI_addr,
    input  logic [31:0]       ramI_dout,
    output logic [ADDR_W-1:0] ramO_addr,
    output logic [31:0]       ramO_din,
    output logic              ramO_we,
    output logic [63:0]       des_in,
    output logic [3:0]        des_roundSel,
    output logic              des_decrypt,
    input  logic [63:0]       des_out,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-2:0] blk_done
);

    localparam int KW = ADDR_W - 1;

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, ROUND, HOLD, WR0, WR1, NEXT, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] count_q, count_d;
    logic [KW-1:0] blk_done_q, blk_done_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic [63:0]   des_in_q, des_in_d;
    logic [63:0]   result_q, result_d;
    logic [3:0]    round_q, round_d;
    logic [1:0]    hold_q, hold_d;
    logic          capture;
    logic [63:0]   blk_word;

`ifdef DES_CBC_EN
    logic [63:0]   chain_q, chain_d;
`else
    logic          unused_iv;
    assign unused_iv = ^iv;
`endif

    // State and datapath registers; everything returns to zero on reset.
    always_ff @(posedge ti_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            count_q    <= '0;
            blk_done_q <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            des_in_q   <= '0;
            result_q   <= '0;
            round_q    <= '0;
            hold_q     <= '0;
`ifdef DES_CBC_EN
            chain_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            count_q    <= count_d;
            blk_done_q <= blk_done_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            des_in_q   <= des_in_d;
            result_q   <= result_d;
            round_q    <= round_d;
            hold_q     <= hold_d;
`ifdef DES_CBC_EN
            chain_q    <= chain_d;
`endif
        end
    end

    // Next-state logic. A count of 0 means the full RAM: k+1 wraps to 0 after
    // the last block, which matches the latched zero, so one compare covers both.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        count_d    = count_q;
        blk_done_d = blk_done_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        des_in_d   = des_in_q;
        result_d   = result_q;
        round_d    = round_q;
        hold_d     = hold_q;
        capture    = 1'b0;
        blk_word   = {ramI_dout, des_in_q[31:0]};
`ifdef DES_CBC_EN
        chain_d    = chain_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    mode_d     = decrypt;
                    count_d    = blk_count;
                    k_d        = '0;
                    blk_done_d = '0;
                    busy_d     = 1'b1;
`ifdef DES_CBC_EN
                    chain_d    = iv;
`endif
                    state_d    = RD0;
                end
            end
            RD0: state_d = RD1;
            RD1: begin
                des_in_d[31:0] = ramI_dout;
                state_d        = RD2;
            end
            RD2: begin
`ifdef DES_CBC_EN
                // Decrypt keeps the raw ciphertext in des_in so it can become
                // the next chain value at capture time.
                des_in_d = mode_q ? blk_word : (blk_word ^ chain_q);
`else
                des_in_d = blk_word;
`endif
                round_d  = 4'd0;
                state_d  = ROUND;
            end
            ROUND: begin
                if (round_q == 4'd15) begin
                    if (CAPTURE_DLY == 0) begin
                        capture = 1'b1;
                        state_d = WR0;
                    end else begin
                        hold_d  = 2'd0;
                        state_d = HOLD;
                    end
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            HOLD: begin
                if (int'(hold_q) == CAPTURE_DLY - 1) begin
                    capture = 1'b1;
                    state_d = WR0;
                end else begin
                    hold_d = hold_q + 2'd1;
                end
            end
            WR0: state_d = WR1;
            WR1: begin
                blk_done_d = blk_done_q + KW'(1);
                state_d    = NEXT;
            end
            NEXT: begin
                if (k_q + KW'(1) == count_q) begin
                    state_d = DONE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = RD0;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
`ifdef DES_CBC_EN
            if (mode_q) begin
                result_d = des_out ^ chain_q;
                chain_d  = des_in_q;
            end else begin
                result_d = des_out;
                chain_d  = des_out;
            end
`else
            result_d = des_out;
`endif
        end

        // Abort wins over everything while a run is active.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end
    end

    // RAM port drive, decoded from the current state.
    always_comb begin
        ramI_addr = '0;
        ramO_addr = '0;
        ramO_din  = '0;
        ramO_we   = 1'b0;
        case (state_q)
            RD0: ramI_addr = {k_q, 1'b0};
            RD1: ramI_addr = {k_q, 1'b1};
            WR0: begin
                ramO_addr = {k_q, 1'b0};
                ramO_din  = result_q[31:0];
                ramO_we   = 1'b1;
            end
            WR1: begin
                ramO_addr = {k_q, 1'b1};
                ramO_din  = result_q[63:32];
                ramO_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign des_in       = des_in_q;
    assign des_roundSel = round_q;
    assign des_decrypt  = mode_q;
    assign busy         = busy_q;
    assign done         = (state_q == DONE);
    assign blk_done     = blk_done_q;

endmodule

// File: tb/tb_des_block_sequencer.sv
// Testbench for des_block_sequencer with default parameters (ADDR_W=9,
// CAPTURE_DLY=0). Holds behavioural input/output RAMs and a stand-in DES core
// (swap halves, xor with a key) that only presents a valid result while
// des_roundSel is 15.
module tb_des_block_sequencer;

    localparam logic [63:0] KEY = 64'h0F1E2D3C4B5A6978;

    logic        ti_clk;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        decrypt;
    logic [7:0]  blk_count;
    logic [63:0] iv;
    logic [8:0]  ramI_addr;
    logic [31:0] ramI_dout;
    logic [8:0]  ramO_addr;
    logic [31:0] ramO_din;
    logic        ramO_we;
    logic [63:0] des_in;
    logic [3:0]  des_roundSel;
    logic        des_decrypt;
    logic [63:0] des_out;
    logic        busy;
    logic        done;
    logic [7:0]  blk_done;

    logic [31:0] ram_i [0:511];
    logic [31:0] ram_o [0:511];
    logic [31:0] exp_q [$];
    logic [31:0] pt_save [0:7];

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;

    des_block_sequencer #(.ADDR_W(9), .CAPTURE_DLY(0)) dut (
        .ti_clk(ti_clk), .reset_n(reset_n), .start(start), .abort(abort),
        .decrypt(decrypt), .blk_count(blk_count), .iv(iv),
        .ramI_addr(ramI_addr), .ramI_dout(ramI_dout),
        .ramO_addr(ramO_addr), .ramO_din(ramO_din), .ramO_we(ramO_we),
        .des_in(des_in), .des_roundSel(des_roundSel), .des_decrypt(des_decrypt),
        .des_out(des_out), .busy(busy), .done(done), .blk_done(blk_done)
    );

    // ---------------- clock / reset ----------------
    initial begin
        ti_clk = 1'b0;
        forever #5 ti_clk = ~ti_clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- environment models ----------------
    function automatic logic [63:0] core_f(input logic [63:0] x, input logic dec);
        logic [63:0] y;
        if (!dec) begin
            y = {x[31:0], x[63:32]} ^ KEY;
        end else begin
            y = x ^ KEY;
            y = {y[31:0], y[63:32]};
        end
        return y;
    endfunction

    assign des_out = (des_roundSel == 4'd15) ? core_f(des_in, des_decrypt)
                                             : 64'hBAD0BAD0BAD0BAD0;

    always @(posedge ti_clk) begin
        ramI_dout <= ram_i[ramI_addr];
        if (ramO_we) begin
            ram_o[ramO_addr] <= ramO_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected output words for a run, computed from the current ram_i contents.
    task automatic build_exp(input int n, input logic dec, input logic [63:0] ivv);
        logic [63:0] chain, p, c;
        chain = ivv;
        for (int b = 0; b < n; b++) begin
            p = {ram_i[2*b+1], ram_i[2*b]};
`ifdef DES_CBC_EN
            if (!dec) begin
                c = core_f(p ^ chain, 1'b0);
                chain = c;
            end else begin
                c = core_f(p, 1'b1) ^ chain;
                chain = p;
            end
`else
            c = core_f(p, dec);
`endif
            exp_q.push_back(c[31:0]);
            exp_q.push_back(c[63:32]);
        end
    endtask

    task automatic sb_compare(input string tag);
        int w;
        logic [31:0] e;
        w = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_w%0d", tag, w), {32'b0, ram_o[w]}, {32'b0, e});
            w++;
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick;
        @(posedge ti_clk);
        #1;
    endtask

    // Returns in cycle 1 of the run (start was cycle 0).
    task automatic start_run(input logic dec, input logic [7:0] cnt, input logic [63:0] ivv);
        decrypt   = dec;
        blk_count = cnt;
        iv        = ivv;
        start     = 1'b1;
        tick;
        start     = 1'b0;
    endtask

    // Returns with lat = cycle index of done, or -1 on timeout.
    task automatic wait_done(input int budget, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            tick;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat, wc0, dc0;
        logic [63:0] ecb0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; decrypt = 1'b0;
        blk_count = '0; iv = '0;
        repeat (3) tick;
        reset_n = 1'b1;
        tick;

        check("rst_ramI_addr", {55'b0, ramI_addr}, 64'd0);
        check("rst_ramO_addr", {55'b0, ramO_addr}, 64'd0);
        check("rst_ramO_din",  {32'b0, ramO_din}, 64'd0);
        check("rst_ramO_we",   {63'b0, ramO_we}, 64'd0);
        check("rst_des_in",    des_in, 64'd0);
        check("rst_roundsel",  {60'b0, des_roundSel}, 64'd0);
        check("rst_decrypt",   {63'b0, des_decrypt}, 64'd0);
        check("rst_busy",      {63'b0, busy}, 64'd0);
        check("rst_done",      {63'b0, done}, 64'd0);
        check("rst_blk_done",  {56'b0, blk_done}, 64'd0);

        // Single block, hand-computed result.
        ram_i[0] = 32'h89ABCDEF;
        ram_i[1] = 32'h01234567;
        wc0 = wr_cnt; dc0 = done_cnt;
        start_run(1'b0, 8'd1, 64'd0);
        check("single_busy", {63'b0, busy}, 64'd1);
        wait_done(200, lat);
        check("single_lat", lat, 64'd23);
        check("single_blk_done", {56'b0, blk_done}, 64'd1);
        tick;
        check("single_busy_after", {63'b0, busy}, 64'd0);
        check("single_w0", {32'b0, ram_o[0]}, 64'h4A792C1F);
        check("single_w1", {32'b0, ram_o[1]}, 64'h86B5E0D3);
        check("single_writes", wr_cnt - wc0, 64'd2);
        check("single_dones", done_cnt - dc0, 64'd1);

        // Round trip: 4 blocks encrypt, copy back, decrypt.
        for (int i = 0; i < 8; i++) begin
            ram_i[i]   = $urandom;
            pt_save[i] = ram_i[i];
        end
        iv = {$urandom, $urandom};
        build_exp(4, 1'b0, iv);
        dc0 = done_cnt;
        start_run(1'b0, 8'd4, iv);
        wait_done(300, lat);
        check("rt_enc_lat", lat, 64'd89);
        tick;
        sb_compare("rt_enc");
        check("rt_enc_dones", done_cnt - dc0, 64'd1);
        for (int i = 0; i < 8; i++) ram_i[i] = ram_o[i];
        dc0 = done_cnt;
        start_run(1'b1, 8'd4, iv);
        check("rt_des_decrypt", {63'b0, des_decrypt}, 64'd1);
        wait_done(300, lat);
        check("rt_dec_lat", lat, 64'd89);
        tick;
        for (int i = 0; i < 8; i++)
            check($sformatf("rt_plain_w%0d", i), {32'b0, ram_o[i]}, {32'b0, pt_save[i]});
        check("rt_dec_dones", done_cnt - dc0, 64'd1);

        // Full RAM: blk_count 0 means 256 blocks.
        for (int i = 0; i < 512; i++) ram_i[i] = $urandom;
        build_exp(256, 1'b0, 64'd0);
        wc0 = wr_cnt;
        start_run(1'b0, 8'd0, 64'd0);
        wait_done(7000, lat);
        check("full_lat", lat, 64'd5633);
        check("full_blk_done", {56'b0, blk_done}, 64'd0);
        tick;
        check("full_writes", wr_cnt - wc0, 64'd512);
        sb_compare("full");

        // Abort in ROUND of block 2, with an ignored start at cycle 10.
        wc0 = wr_cnt; dc0 = done_cnt;
        start_run(1'b0, 8'd4, 64'd0);
        for (int c = 1; c < 10; c++) tick;
        start = 1'b1; decrypt = 1'b1; blk_count = 8'd1;
        tick;
        start = 1'b0; decrypt = 1'b0;
        check("ign_start_decrypt", {63'b0, des_decrypt}, 64'd0);
        check("ign_start_busy", {63'b0, busy}, 64'd1);
        for (int c = 11; c < 55; c++) tick;
        check("abort_roundsel", {60'b0, des_roundSel}, 64'd7);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_we", {63'b0, ramO_we}, 64'd0);
        check("abort_writes_before", wr_cnt - wc0, 64'd4);
        wc0 = wr_cnt;
        repeat (60) tick;
        check("abort_writes_after", wr_cnt - wc0, 64'd0);
        check("abort_dones", done_cnt - dc0, 64'd0);
        check("abort_blk_done", {56'b0, blk_done}, 64'd2);

        // Abort while idle, and abort with start in the same cycle.
        abort = 1'b1;
        tick;
        check("idle_abort_busy", {63'b0, busy}, 64'd0);
        start = 1'b1;
        tick;
        start = 1'b0; abort = 1'b0;
        tick;
        check("abort_start_busy", {63'b0, busy}, 64'd0);
        check("abort_start_addr", {55'b0, ramI_addr}, 64'd0);

        // Reset asserted during WR0, then a clean decrypt run.
        ram_i[0] = 32'h4A792C1F;
        ram_i[1] = 32'h86B5E0D3;
        dc0 = done_cnt;
        start_run(1'b1, 8'd1, 64'd0);
        for (int c = 1; c < 20; c++) tick;
        check("wr0_we", {63'b0, ramO_we}, 64'd1);
        reset_n = 1'b0;
        #1;
        check("arst_we", {63'b0, ramO_we}, 64'd0);
        check("arst_busy", {63'b0, busy}, 64'd0);
        check("arst_ramO_din", {32'b0, ramO_din}, 64'd0);
        check("arst_des_in", des_in, 64'd0);
        check("arst_roundsel", {60'b0, des_roundSel}, 64'd0);
        check("arst_decrypt", {63'b0, des_decrypt}, 64'd0);
        repeat (2) tick;
        reset_n = 1'b1;
        tick;
        check("arst_dones", done_cnt - dc0, 64'd0);
        wc0 = wr_cnt;
        start_run(1'b1, 8'd1, 64'd0);
        wait_done(200, lat);
        check("post_rst_lat", lat, 64'd23);
        tick;
        check("post_rst_w0", {32'b0, ram_o[0]}, 64'h89ABCDEF);
        check("post_rst_w1", {32'b0, ram_o[1]}, 64'h01234567);
        check("post_rst_writes", wr_cnt - wc0, 64'd2);

`ifdef DES_CBC_EN
        // CBC with an all-ones iv: block 0 must differ from its ECB encryption.
        for (int i = 0; i < 4; i++) ram_i[i] = $urandom;
        ecb0 = core_f({ram_i[1], ram_i[0]}, 1'b0);
        build_exp(2, 1'b0, 64'hFFFFFFFFFFFFFFFF);
        start_run(1'b0, 8'd2, 64'hFFFFFFFFFFFFFFFF);
        wait_done(200, lat);
        check("cbc_lat", lat, 64'd45);
        tick;
        sb_compare("cbc_ones");
        check("cbc_differs_ecb", {63'b0, ({ram_o[1], ram_o[0]} != ecb0)}, 64'd1);
`else
        ecb0 = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
